// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl
//   Multi-digit seven-segment display controller. A value of N_DIGITS nibbles
//   is accepted over a valid/ready handshake and decoded one digit per cycle,
//   most significant digit first, into a staging buffer. The staging buffer is
//   copied to the visible display registers in a single cycle, so a partly
//   decoded frame never reaches the display. Leading zeros can be blanked
//   (captured per frame), and each digit can blink under a live mask.
//
// Optional feature macro: HEX_DP_EN (adds decimal-point input/output).
//
// Ports
//   clk         in   1            system clock, rising edge
//   rst         in   1            synchronous reset, active-high
//   val         in   4*N_DIGITS   value to display, nibble i -> digit i
//   val_valid   in   1            val/blank_lz offered this cycle
//   val_ready   out  1            controller idle, accepts on val_valid
//   blank_lz    in   1            captured with val, 1 = blank leading zeros
//   blink_mask  in   N_DIGITS     live per-digit blink enable
//   dp_in       in   N_DIGITS     (HEX_DP_EN) decimal points, captured with val
//   dp          out  N_DIGITS     (HEX_DP_EN) decimal point drive per digit
//   hex         out  7*N_DIGITS   digit i on hex[7*i+6:7*i], bits g..a
//   upd_done    out  1            one-cycle pulse when a frame is committed
// ---------------------------------------------------------------------------
module hex_display_ctrl #(
  parameter int N_DIGITS   = 8,
  parameter int BLINK_DIV  = 25_000_000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] val,
  input  logic                  val_valid,
  output logic                  val_ready,
  input  logic                  blank_lz,
  input  logic [N_DIGITS-1:0]   blink_mask,
`ifdef HEX_DP_EN
  input  logic [N_DIGITS-1:0]   dp_in,
  output logic [N_DIGITS-1:0]   dp,
`endif
  output logic [7*N_DIGITS-1:0] hex,
  output logic                  upd_done
);

  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DECODE = 2'd1;
  localparam logic [1:0] ST_COMMIT = 2'd2;

  // Segments are held internally in active-low form; polarity is applied
  // only at the output pins.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] OUT_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0: g = 7'h40;
      4'h1: g = 7'h79;
      4'h2: g = 7'h24;
      4'h3: g = 7'h30;
      4'h4: g = 7'h19;
      4'h5: g = 7'h12;
      4'h6: g = 7'h02;
      4'h7: g = 7'h78;
      4'h8: g = 7'h00;
      4'h9: g = 7'h18;
      4'hA: g = 7'h08;
      4'hB: g = 7'h03;
      4'hC: g = 7'h46;
      4'hD: g = 7'h21;
      4'hE: g = 7'h06;
      default: g = 7'h0E;
    endcase
    return g;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [4*N_DIGITS-1:0] val_q, val_d;
  logic                  lz_q, lz_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [6:0]            staging_q [N_DIGITS];
  logic [6:0]            staging_d [N_DIGITS];
  logic [6:0]            display_q [N_DIGITS];
  logic [6:0]            display_d [N_DIGITS];
  logic                  upd_q, upd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  phase_q, phase_d;
  logic [3:0]            nib [N_DIGITS];
  logic [3:0]            cur_nib;

`ifdef HEX_DP_EN
  logic [N_DIGITS-1:0]   dp_cap_q, dp_cap_d;
  logic [N_DIGITS-1:0]   dp_disp_q, dp_disp_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_nib
      assign nib[gi] = val_q[4*gi +: 4];
    end
  endgenerate

  assign cur_nib   = nib[idx_q];
  assign val_ready = (state_q == ST_IDLE);
  assign upd_done  = upd_q;

  // Frame FSM next-state logic.
  always_comb begin
    state_d   = state_q;
    val_d     = val_q;
    lz_d      = lz_q;
    idx_d     = idx_q;
    staging_d = staging_q;
    display_d = display_q;
    upd_d     = 1'b0;
`ifdef HEX_DP_EN
    dp_cap_d  = dp_cap_q;
    dp_disp_d = dp_disp_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (val_valid) begin
          val_d   = val;
          lz_d    = blank_lz;
          idx_d   = IDX_W'(N_DIGITS - 1);
          state_d = ST_DECODE;
`ifdef HEX_DP_EN
          dp_cap_d = dp_in;
`endif
        end
      end
      ST_DECODE: begin
        // Digit 0 is always shown so that a zero value still reads "0".
        if (lz_q && (cur_nib == 4'h0) && (idx_q != '0)) begin
          staging_d[idx_q] = SEG_OFF;
        end else begin
          staging_d[idx_q] = glyph(cur_nib);
          lz_d             = 1'b0;
        end
        if (idx_q == '0) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      ST_COMMIT: begin
        display_d = staging_q;
        upd_d     = 1'b1;
        state_d   = ST_IDLE;
`ifdef HEX_DP_EN
        dp_disp_d = dp_cap_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Free-running blink timebase, independent of the frame FSM.
  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    if (cnt_q == CNT_W'(BLINK_DIV - 1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      val_q   <= '0;
      lz_q    <= 1'b0;
      idx_q   <= '0;
      upd_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b0;
      for (int i = 0; i < N_DIGITS; i++) begin
        staging_q[i] <= SEG_OFF;
        display_q[i] <= SEG_OFF;
      end
`ifdef HEX_DP_EN
      dp_cap_q  <= '0;
      dp_disp_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      val_q     <= val_d;
      lz_q      <= lz_d;
      idx_q     <= idx_d;
      upd_q     <= upd_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      staging_q <= staging_d;
      display_q <= display_d;
`ifdef HEX_DP_EN
      dp_cap_q  <= dp_cap_d;
      dp_disp_q <= dp_disp_d;
`endif
    end
  end

  // Output stage: blink masking and polarity. Forced dark while rst is high
  // so the pins are defined even before the first reset edge.
  generate
    for (gi = 0; gi < N_DIGITS; gi++) begin : g_out
      logic [6:0] seg;
      assign seg = (blink_mask[gi] && phase_q) ? SEG_OFF : display_q[gi];
      assign hex[7*gi +: 7] = rst ? OUT_OFF : (ACTIVE_LOW ? seg : ~seg);
`ifdef HEX_DP_EN
      logic dp_lit;
      assign dp_lit = dp_disp_q[gi] && !(blink_mask[gi] && phase_q) && !rst;
      assign dp[gi] = ACTIVE_LOW ? ~dp_lit : dp_lit;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_hex_display_ctrl.sv
module tb_hex_display_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] val;
  logic        val_valid;
  logic        val_ready;
  logic        blank_lz;
  logic [3:0]  blink_mask;
  logic [27:0] hex;
  logic        upd_done;

  int checks = 0;
  int errors = 0;

  // Cycles since reset release; the blink phase follows directly from it.
  int unsigned n_since_rst;

  logic [27:0] cur_hex;

  hex_display_ctrl #(
    .N_DIGITS  (4),
    .BLINK_DIV (4),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .val       (val),
    .val_valid (val_valid),
    .val_ready (val_ready),
    .blank_lz  (blank_lz),
    .blink_mask(blink_mask),
    .hex       (hex),
    .upd_done  (upd_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) n_since_rst <= 0;
    else     n_since_rst <= n_since_rst + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
    $display("check %-18s observed %h expected %h", tag, obs, exp);
  endtask

  task automatic wait_ready(input string tag);
    int t = 0;
    while (val_ready !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_rdy"}, {31'd0, val_ready}, 32'd1);
  endtask

  // Offer one frame and follow it through decode and commit. With inject set,
  // a competing 16'hFFFF offer is held during decode and must be ignored.
  task automatic load(input string tag, input logic [15:0] v, input logic blz,
                      input logic [27:0] exp_hex, input bit inject);
    wait_ready(tag);
    val = v; blank_lz = blz; val_valid = 1'b1;
    @(negedge clk);                 // E0 has captured the frame
    val_valid = 1'b0; val = 16'h0; blank_lz = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (inject && i == 1) begin val = 16'hFFFF; val_valid = 1'b1; end
      if (inject && i == 3) begin val = 16'h0;    val_valid = 1'b0; end
      check({tag, "_busy"}, {31'd0, val_ready}, 32'd0);
      check({tag, "_noupd"}, {31'd0, upd_done}, 32'd0);
      check({tag, "_hold"}, {4'd0, hex}, {4'd0, cur_hex});
      @(negedge clk);
    end
    check({tag, "_upd"}, {31'd0, upd_done}, 32'd1);
    check({tag, "_rdy1"}, {31'd0, val_ready}, 32'd1);
    check({tag, "_hex"}, {4'd0, hex}, {4'd0, exp_hex});
    cur_hex = exp_hex;
    @(negedge clk);
    check({tag, "_upd0"}, {31'd0, upd_done}, 32'd0);
    check({tag, "_hex2"}, {4'd0, hex}, {4'd0, exp_hex});
  endtask

  initial begin
    rst = 1'b1; val = 16'h0; val_valid = 1'b0; blank_lz = 1'b0; blink_mask = 4'b0;
    cur_hex = 28'hFFFFFFF;

    // Reset held for two cycles
    @(negedge clk);
    check("rst_hex_in", {4'd0, hex}, 32'h0FFFFFFF);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_hex", {4'd0, hex}, 32'h0FFFFFFF);
    check("rst_ready", {31'd0, val_ready}, 32'd1);
    check("rst_upd", {31'd0, upd_done}, 32'd0);

    load("f12AF", 16'h12AF, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}, 1'b0);
    load("f0030", 16'h0030, 1'b1, {7'h7F, 7'h7F, 7'h30, 7'h40}, 1'b0);
    load("f0000", 16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0);
    load("f1234", 16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}, 1'b1);

    // Ignored offer must not start a new frame once idle again
    check("ign_rdy", {31'd0, val_ready}, 32'd1);
    @(negedge clk);
    check("ign_noupd", {31'd0, upd_done}, 32'd0);

    // Blink digit 0: phase is 1 during cycles 4..7 mod 8 after reset
    blink_mask = 4'b0001;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("blink_d0", {25'd0, hex[6:0]},
            ((n_since_rst / 4) % 2 == 1) ? 32'h7F : 32'h19);
      check("blink_hi", {11'd0, hex[27:7]}, {11'd0, 7'h79, 7'h24, 7'h30});
    end
    blink_mask = 4'b0000;
    @(negedge clk);
    check("blink_off", {4'd0, hex}, {4'd0, 7'h79, 7'h24, 7'h30, 7'h19});

    // Reset during decode aborts the frame
    wait_ready("abort");
    val = 16'h5678; val_valid = 1'b1;
    @(negedge clk);
    val_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_hex", {4'd0, hex}, 32'h0FFFFFFF);
    check("abort_rdy", {31'd0, val_ready}, 32'd1);
    check("abort_upd", {31'd0, upd_done}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("abort_noupd", {31'd0, upd_done}, 32'd0);
      check("abort_dark", {4'd0, hex}, 32'h0FFFFFFF);
    end
    cur_hex = 28'hFFFFFFF;

    load("f00A0", 16'h00A0, 1'b1, {7'h7F, 7'h7F, 7'h08, 7'h40}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
